// File: rtl/seq_match_controller_pkg.sv
// Shared types and display helpers for the serial-pattern match controller.
package seq_ctrl_pkg;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    HUNT  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [7:0] SEG_DASH = 8'h40;

  // Segment bits are {g,f,e,d,c,b,a}, active high.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      4'hF: hex7 = 7'h71;
    endcase
  endfunction

endpackage

// File: rtl/seq_match_controller_sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous pin plus a rising-edge pulse.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = o_level & ~r_prev;

endmodule

// File: rtl/seq_match_controller.sv
// Serial-pattern match controller: counts pattern hits and shows them on a
// 7-segment digit, with the decimal point held for a window after each hit.
//   state | meaning
//   UNCFG | no pattern loaded, display "-", strobes ignored
//   HUNT  | searching, display hex count, dp off
//   HOLD  | recent match, display hex count, dp on until timer expires
module seq_match_controller
  import seq_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 5000000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ena,
  input  logic       i_bit_in,
  input  logic       i_bit_strobe,
  input  logic       i_cfg_load,
  input  logic [7:0] i_cfg_pattern,
  input  logic [2:0] i_cfg_len,
  input  logic       i_overlap_en,
  input  logic       i_clr_count,
  output logic [7:0] o_seg_out,
  output logic       o_match_pulse
);

  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_bit_sync;
  state_t                 r_state, w_state_nxt;
  logic [7:0]             r_history, w_hist_nxt;
  logic [3:0]             r_fill, w_fill_nxt;
  logic [3:0]             r_count, w_count_nxt;
  logic [TW-1:0]          r_timer, w_timer_nxt;
  logic [7:0]             r_pattern;
  logic [2:0]             r_len;
  logic                   r_shifted, w_shifted_nxt;
  logic [7:0]             w_mask, w_seg_nxt;
  logic                   w_bit, w_match;
  logic                   w_strobe_rise, w_cfg_rise;
  logic                   w_unused_strobe_lvl, w_unused_cfg_lvl;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_strobe_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_bit_strobe),
    .o_level (w_unused_strobe_lvl),
    .o_rise  (w_strobe_rise)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_cfg_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_cfg_load),
    .o_level (w_unused_cfg_lvl),
    .o_rise  (w_cfg_rise)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_bit_sync <= '0;
    else          r_bit_sync <= {r_bit_sync[SYNC_STAGES-2:0], i_bit_in};
  end

  assign w_bit = r_bit_sync[SYNC_STAGES-1];

  // Match is evaluated once, on the cycle right after a shift.
  always_comb begin
    w_mask  = 8'hFF >> (3'd7 - r_len);
    w_match = i_ena && r_shifted && (r_state != UNCFG) && !w_cfg_rise &&
              (r_fill >= ({1'b0, r_len} + 4'd1)) &&
              ((r_history & w_mask) == (r_pattern & w_mask));
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_hist_nxt    = r_history;
    w_fill_nxt    = r_fill;
    w_count_nxt   = r_count;
    w_timer_nxt   = r_timer;
    w_shifted_nxt = r_shifted;
    if (i_ena) begin
      if (w_cfg_rise) begin
        w_state_nxt   = HUNT;
        w_hist_nxt    = '0;
        w_fill_nxt    = '0;
        w_count_nxt   = '0;
        w_timer_nxt   = '0;
        w_shifted_nxt = 1'b0;
      end else if (r_state != UNCFG) begin
        w_shifted_nxt = 1'b0;
        if (w_match && !i_overlap_en) w_fill_nxt = '0;
        if (w_strobe_rise) begin
          w_hist_nxt    = {r_history[6:0], w_bit};
          w_fill_nxt    = (w_fill_nxt == 4'd8) ? 4'd8 : w_fill_nxt + 4'd1;
          w_shifted_nxt = 1'b1;
        end
        if (w_match) begin
          w_count_nxt = r_count + 4'd1;
          w_state_nxt = HOLD;
          w_timer_nxt = TIMER_LOAD;
        end else if (r_state == HOLD) begin
          if (r_timer == '0) w_state_nxt = HUNT;
          else               w_timer_nxt = r_timer - TW'(1);
        end
        if (i_clr_count) w_count_nxt = '0;
      end
    end
    // Display is derived from next-state values so it changes on the same edge.
    if (w_state_nxt == UNCFG) w_seg_nxt = SEG_DASH;
    else                      w_seg_nxt = {w_state_nxt == HOLD, hex7(w_count_nxt)};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= UNCFG;
      r_history     <= '0;
      r_fill        <= '0;
      r_count       <= '0;
      r_timer       <= '0;
      r_shifted     <= 1'b0;
      o_seg_out     <= SEG_DASH;
      o_match_pulse <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_history     <= w_hist_nxt;
      r_fill        <= w_fill_nxt;
      r_count       <= w_count_nxt;
      r_timer       <= w_timer_nxt;
      r_shifted     <= w_shifted_nxt;
      o_seg_out     <= w_seg_nxt;
      o_match_pulse <= w_match;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pattern <= '0;
      r_len     <= '0;
    end else if (i_ena && w_cfg_rise) begin
      r_pattern <= i_cfg_pattern;
      r_len     <= i_cfg_len;
    end
  end

endmodule

// File: tb/tb_seq_match_controller.sv
// Directed bench for seq_match_controller with an event-level reference model.
module tb_seq_match_controller;

  localparam int SYNC = 2;
  localparam int HOLD = 8;

  logic       clk, rst_n, ena, bit_in, bit_strobe, cfg_load;
  logic [7:0] cfg_pattern;
  logic [2:0] cfg_len;
  logic       overlap_en, clr_count;
  logic [7:0] seg_out;
  logic       match_pulse;

  seq_match_controller #(.SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_ena         (ena),
    .i_bit_in      (bit_in),
    .i_bit_strobe  (bit_strobe),
    .i_cfg_load    (cfg_load),
    .i_cfg_pattern (cfg_pattern),
    .i_cfg_len     (cfg_len),
    .i_overlap_en  (overlap_en),
    .i_clr_count   (clr_count),
    .o_seg_out     (seg_out),
    .o_match_pulse (match_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int         due;
    logic       b;
    logic       is_cfg;
    logic [7:0] pat;
    logic [2:0] len;
  } ev_t;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_pulses = 0;
  int   last_pulse_cyc = -1;
  ev_t  ev_q[$];

  // Model state: received bits since last clear, count, last-match cycle.
  logic       m_cfg = 1'b0;
  logic [7:0] m_pat = '0;
  logic [2:0] m_len = '0;
  logic       m_bits[$];
  int         m_count = 0;
  logic       m_has = 1'b0;
  int         m_last = 0;
  logic       m_pulse = 1'b0;
  logic [7:0] m_seg = 8'h40;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_event(input ev_t e);
    int  l;
    bit  hit;
    if (e.is_cfg) begin
      m_cfg = 1'b1; m_pat = e.pat; m_len = e.len;
      m_bits.delete(); m_count = 0; m_has = 1'b0;
    end else if (m_cfg) begin
      m_bits.push_back(e.b);
      if (m_bits.size() > 8) void'(m_bits.pop_front());
      l = int'(m_len) + 1;
      hit = 1'b0;
      if (m_bits.size() >= l) begin
        hit = 1'b1;
        for (int i = 0; i < l; i++)
          if (m_bits[m_bits.size()-1-i] != m_pat[i]) hit = 1'b0;
      end
      if (hit) begin
        m_pulse = 1'b1;
        m_count = (m_count + 1) % 16;
        m_has   = 1'b1;
        m_last  = cyc;
        if (!overlap_en) m_bits.delete();
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cfg = 1'b0; m_bits.delete(); ev_q.delete();
      m_count = 0; m_has = 1'b0; m_pulse = 1'b0; m_seg = 8'h40;
    end else begin
      cyc++;
      m_pulse = 1'b0;
      for (int i = 0; i < ev_q.size(); ) begin
        if (ev_q[i].due == cyc) begin
          model_event(ev_q[i]);
          ev_q.delete(i);
        end else i++;
      end
      if (m_cfg && ena && clr_count) m_count = 0;
      if (!m_cfg) m_seg = 8'h40;
      else        m_seg = {(m_has && (cyc < m_last + HOLD)), hex_tab[m_count]};
    end
  end

  always @(negedge clk) begin
    check("seg_out", {24'h0, seg_out}, {24'h0, m_seg});
    check("match_pulse", {31'h0, match_pulse}, {31'h0, m_pulse});
    if (match_pulse === 1'b1) begin
      n_pulses++;
      last_pulse_cyc = cyc;
    end
  end

  task automatic strobe(input logic b, input logic with_clr, output int k);
    @(negedge clk);
    bit_in = b;
    bit_strobe = 1'b1;
    k = cyc + 1;
    if (ena) ev_q.push_back('{k + SYNC + 1, b, 1'b0, 8'h00, 3'h0});
    repeat (3) @(negedge clk);
    bit_strobe = 1'b0;
    if (with_clr) clr_count = 1'b1;
    @(negedge clk);
    clr_count = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic cfg(input logic [7:0] p, input logic [2:0] l);
    @(negedge clk);
    cfg_pattern = p;
    cfg_len = l;
    cfg_load = 1'b1;
    ev_q.push_back('{cyc + 1 + SYNC, 1'b0, 1'b1, p, l});
    repeat (3) @(negedge clk);
    cfg_load = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic stream(input logic [7:0] bits, input int n, output int k);
    for (int i = n - 1; i >= 0; i--) strobe(bits[i], 1'b0, k);
  endtask

  initial begin
    int k, p0, k_first;
    rst_n = 1'b0; ena = 1'b1; bit_in = 1'b0; bit_strobe = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; overlap_en = 1'b0; clr_count = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_seg", {24'h0, seg_out}, 32'h40);
    rst_n = 1'b1;

    // Unconfigured: strobes ignored
    stream(8'b10110, 5, k);
    repeat (4) @(negedge clk);
    check("uncfg_seg", {24'h0, seg_out}, 32'h40);
    check("uncfg_pulses", n_pulses, 0);

    // Pattern 011, no overlap, stream 0,1,1,0,1,1
    overlap_en = 1'b0;
    cfg(8'b011, 3'd2);
    p0 = n_pulses;
    stream(8'b011, 3, k_first);
    check("first_pulse_latency", last_pulse_cyc, k_first + SYNC + 1);
    stream(8'b011, 3, k);
    check("second_pulse_latency", last_pulse_cyc, k + SYNC + 1);
    check("hold_seg_2", {24'h0, seg_out}, 32'hDB);
    repeat (8) @(negedge clk);
    check("hunt_seg_2", {24'h0, seg_out}, 32'h5B);
    check("pulses_011", n_pulses - p0, 2);

    // Pattern 101, overlap on then off
    overlap_en = 1'b1;
    cfg(8'b101, 3'd2);
    stream(8'b10101, 5, k);
    repeat (8) @(negedge clk);
    check("overlap_count", {24'h0, seg_out}, 32'h5B);
    overlap_en = 1'b0;
    cfg(8'b101, 3'd2);
    stream(8'b10101, 5, k);
    repeat (8) @(negedge clk);
    check("no_overlap_count", {24'h0, seg_out}, 32'h06);

    // Single-bit pattern, 16 hits wrap the count, hold window boundary
    overlap_en = 1'b1;
    cfg(8'b1, 3'd0);
    for (int i = 0; i < 16; i++) strobe(1'b1, 1'b0, k);
    check("wrap_hold_seg", {24'h0, seg_out}, 32'hBF);
    while (cyc < k + SYNC + 1 + HOLD - 1) @(negedge clk);
    check("hold_last_cycle", {24'h0, seg_out}, 32'hBF);
    @(negedge clk);
    check("hold_expired", {24'h0, seg_out}, 32'h3F);

    // Clear coincident with a match
    strobe(1'b1, 1'b0, k);
    check("count_one", {24'h0, seg_out}, 32'h86);
    p0 = n_pulses;
    strobe(1'b1, 1'b1, k);
    check("clr_pulse", n_pulses - p0, 1);
    check("clr_pulse_cycle", last_pulse_cyc, k + SYNC + 1);
    check("clr_seg", {24'h0, seg_out}, 32'hBF);

    // Asynchronous reset mid-hold
    #1 rst_n = 1'b0;
    #1 check("async_reset_seg", {24'h0, seg_out}, 32'h40);
    repeat (2) @(negedge clk);
    check("reset_held_seg", {24'h0, seg_out}, 32'h40);
    #1 rst_n = 1'b1;

    // Enable low freezes; re-enable with strobe high gives no sample
    overlap_en = 1'b1;
    cfg(8'b1, 3'd0);
    check("cfg_after_reset", {24'h0, seg_out}, 32'h3F);
    @(negedge clk);
    ena = 1'b0;
    p0 = n_pulses;
    for (int i = 0; i < 3; i++) strobe(1'b1, 1'b0, k);
    @(negedge clk);
    bit_in = 1'b1;
    bit_strobe = 1'b1;
    repeat (4) @(negedge clk);
    ena = 1'b1;
    repeat (6) @(negedge clk);
    bit_strobe = 1'b0;
    repeat (6) @(negedge clk);
    check("ena_no_pulse", n_pulses - p0, 0);
    check("ena_seg", {24'h0, seg_out}, 32'h3F);
    strobe(1'b1, 1'b0, k);
    check("reenabled_seg", {24'h0, seg_out}, 32'h86);
    check("reenabled_pulse", n_pulses - p0, 1);
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_match_controller.md
Name: seq_match_controller

Overview:
- Programmable serial-pattern match controller for the 7-segment sequence-detector tile.
- Accepts a 1–8 bit pattern and length, samples a serial bit stream on strobe edges, and counts matches (4-bit, hex).
- Drives the 7-segment display: "-" when unconfigured, hex match count otherwise, decimal point lit for a hold window after each match.
- Sits between the pin wrapper (ui_in/uo_out) and the display.

Parameters:
- SYNC_STAGES, 2, flops in each input synchronizer (min 2).
- HOLD_CYCLES, 5000000, clk cycles the dp stays lit after a match (min 1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  design enable; low freezes all sampling and state.
- bit_in  in  1  serial data, asynchronous to clk.
- bit_strobe  in  1  asynchronous; each rising edge samples bit_in.
- cfg_load  in  1  asynchronous; rising edge loads cfg_pattern/cfg_len.
- cfg_pattern  in  8  pattern; bit [L-1] is received first, bit [0] last. Quasi-static.
- cfg_len  in  3  pattern length minus 1 (L = cfg_len+1). Quasi-static.
- overlap_en  in  1  1 = overlapping matches allowed.
- clr_count  in  1  synchronous level clear of the match count.
- seg_out  out  8  {dp,g,f,e,d,c,b,a}, active high.
- match_pulse  out  1  one-cycle pulse per match.

Behaviour:
- Reset (rst_n=0, async):
  - state=UNCFG; count=0; history=0; fill=0; hold timer=0.
  - match_pulse=0; seg_out=8'h40 ("-"); all sync flops 0.
- Input conditioning:
  - bit_in and bit_strobe pass through SYNC_STAGES flops.
  - strobe_rise = sync_strobe & ~prev_strobe.
  - cfg_load gets the same synchronizer and edge detect.
- Latency: let edge N be the first clk edge sampling bit_strobe=1.
  - History updates at edge N+SYNC_STAGES.
  - match_pulse, count and state update at edge N+SYNC_STAGES+1.
- Shift and fill: on strobe_rise with ena=1 and state!=UNCFG:
  - history <= {history[6:0], sync_bit}.
  - fill <= min(fill+1, 8).
- Match condition (combinational, registered next edge): fill >= L and history[L-1:0] == cfg_pattern[L-1:0].
  - On match: match_pulse=1 for one cycle; count <= count+1 (wraps F->0).
  - On match with overlap_en=0: fill <= 0 (history contents retained but masked).
- States:
  - UNCFG: seg_out=8'h40; strobes ignored; cfg_load rise -> HUNT.
  - HUNT: seg_out={1'b0, hex7(count)}; match -> HOLD, timer=HOLD_CYCLES-1.
  - HOLD: seg_out={1'b1, hex7(count)}; bits still processed. Further match reloads the timer and counts. Timer==0 with no match -> HUNT.
- cfg_load rise in any state:
  - Latch pattern/len; clear history, fill and count; go to HUNT.
  - A same-cycle match is discarded.
- clr_count=1: count <= 0.
  - If a match occurs in the same cycle, match_pulse still asserts, count stays 0, and HOLD is entered.
- ena=0: edge detectors still track the pins (no stale edge on re-enable), but no shift, count, state or timer change. Outputs hold.
- hex7 encoding:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Registered outputs: seg_out and match_pulse are registered, no combinational path from inputs.

Decomposition:
- Package seq_ctrl_pkg:
  - state enum {UNCFG, HUNT, HOLD}.
  - SEG_DASH=8'h40.
  - hex7 function.
- One sub-module, sync_edge_detect (parameter SYNC_STAGES; outputs sync level and rise pulse), instanced for bit_strobe and cfg_load.
- bit_in uses a plain synchronizer chain in the parent.

Test Plan:
- Reset, no cfg_load, 5 strobes -> seg_out stays 8'h40, match_pulse never asserts.
- cfg_pattern=8'b011, cfg_len=2, overlap_en=0, stream 0,1,1,0,1,1 -> two match_pulses, each SYNC_STAGES+1 edges after the final strobe. seg_out ends 8'hDB (dp + "2") during HOLD, then 8'h5B.
- cfg_pattern=8'b101, cfg_len=2, stream 1,0,1,0,1:
  - overlap_en=1 -> count 2 (8'h5B).
  - overlap_en=0 -> count 1 (8'h06).
- HOLD_CYCLES=8, pattern 1 (cfg_len=0), 16 strobes of 1 -> count wraps to 0, seg_out=8'hBF in HOLD, then 8'h3F 8 cycles after the last match.
- Match edge coincident with clr_count=1 -> match_pulse=1, seg_out=8'hBF. Then assert rst_n=0 mid-HOLD -> seg_out=8'h40 immediately (async), state UNCFG.
- ena=0 while strobing the matching pattern -> no pulse, count unchanged. Re-enable with strobe held high -> no spurious sample.
